// File: rtl/uc_pkg.sv
// Shared unit-clause types: signed literal type, empty-literal constant,
// selection mode encoding and a magnitude helper.
package uc_pkg;

  localparam int LIT_IDX_MAX = 63;
  localparam int LIT_W_DEF   = $clog2(LIT_IDX_MAX) + 1;

  typedef logic signed [LIT_W_DEF-1:0] lit_t;

  localparam lit_t LIT_NONE = '0;

  typedef enum logic {
    MODE_FIFO = 1'b0,
    MODE_PQ   = 1'b1
  } mode_e;

  // Unsigned magnitude of a signed literal (the most negative code is never used)
  function automatic logic [LIT_W_DEF-1:0] lit_abs(input lit_t lit);
    return lit[LIT_W_DEF-1] ? LIT_W_DEF'(-lit) : LIT_W_DEF'(lit);
  endfunction

endpackage

// File: rtl/uc_min_select.sv
// Priority-queue selector: a binary tournament over {valid, |lit|, slot}
// returning the slot holding the smallest magnitude, lowest slot on ties.
module uc_min_select
  import uc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LIT_W = LIT_W_DEF
) (
  input  logic [DEPTH-1:0]            slotValid_i,
  input  logic [DEPTH-1:0][LIT_W-1:0] slotLit_i,
  output logic [$clog2(DEPTH)-1:0]    selIdx_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEAVES = 1 << IDX_W;

  // Heap-indexed tree: leaves at LEAVES+i, each parent keeps the better child (left wins ties)
  always_comb begin : treeSelect
    logic             nodeValid [2*LEAVES];
    logic [LIT_W-1:0] nodeAbs   [2*LEAVES];
    logic [IDX_W-1:0] nodeIdx   [2*LEAVES];
    for (int n = 0; n < 2*LEAVES; n++) begin
      nodeValid[n] = 1'b0;
      nodeAbs[n]   = '0;
      nodeIdx[n]   = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      nodeValid[LEAVES+i] = slotValid_i[i];
      nodeAbs[LEAVES+i]   = slotLit_i[i][LIT_W-1] ? ((~slotLit_i[i]) + LIT_W'(1)) : slotLit_i[i];
      nodeIdx[LEAVES+i]   = IDX_W'(i);
    end
    for (int n = LEAVES - 1; n >= 1; n--) begin
      if (nodeValid[2*n] && (!nodeValid[2*n+1] || (nodeAbs[2*n] <= nodeAbs[2*n+1]))) begin
        nodeValid[n] = nodeValid[2*n];
        nodeAbs[n]   = nodeAbs[2*n];
        nodeIdx[n]   = nodeIdx[2*n];
      end else begin
        nodeValid[n] = nodeValid[2*n+1];
        nodeAbs[n]   = nodeAbs[2*n+1];
        nodeIdx[n]   = nodeIdx[2*n+1];
      end
    end
    selIdx_o = nodeIdx[1];
  end

endmodule

// File: rtl/eng_uc_queue.sv
// Per-engine implied-unit-clause queue. Stores literals oldest-first in a
// compacted array, presents FIFO head or smallest magnitude to the arbiter,
// and snoops the arbiter broadcast to purge assigned literals and flag conflicts.
module eng_uc_queue
  import uc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LIT_W = LIT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic signed [LIT_W-1:0]  push_lit,
  input  logic                     pop,
  input  logic                     bcast_valid,
  input  logic signed [LIT_W-1:0]  uca2eng,
  input  logic                     input_mode,
  output logic signed [LIT_W-1:0]  eng2uca_min,
  output logic                     eng2uca_valid,
  output logic                     eng2uca_empty,
  output logic                     eng2uca_full,
  output logic                     conflict,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][LIT_W-1:0] slotLit_q, slotLit_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic                        conflict_q, conflict_d;
  logic                        overflow_q, overflow_d;

  logic [DEPTH-1:0]            slotValid;
  logic [DEPTH-1:0]            keep;
  logic [IDX_W-1:0]            pqIdx;
  logic [IDX_W-1:0]            selIdx;
  logic [CNT_W-1:0]            keepCount;
  logic signed [LIT_W-1:0]     negBcast;
  logic signed [LIT_W-1:0]     negPush;
  logic                        popFire;
  logic                        purgeConflict;
  logic                        dupHit;
  logic                        negHit;
  logic                        pushReq;
  logic                        bcSame;
  logic                        bcNeg;
  logic                        pushConflict;
  logic                        pushCandidate;
  logic                        pushAccept;
  logic                        pushOverflow;

  // Storage is compacted, so a slot holds a literal exactly when it lies below the count
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slotValid[i] = (CNT_W'(i) < count_q);
    end
  end

  uc_min_select #(
    .DEPTH (DEPTH),
    .LIT_W (LIT_W)
  ) u_minSelect (
    .slotValid_i (slotValid),
    .slotLit_i   (slotLit_q),
    .selIdx_o    (pqIdx)
  );

  assign selIdx   = (input_mode == MODE_PQ) ? pqIdx : '0;
  assign popFire  = pop && (count_q != '0);
  assign negBcast = -uca2eng;
  assign negPush  = -push_lit;

  // Decide which stored slots survive the pop and the broadcast purge, and spot complements of the broadcast
  always_comb begin
    keep          = '0;
    purgeConflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      keep[i] = slotValid[i]
              && !(popFire && (selIdx == IDX_W'(i)))
              && !(bcast_valid && (slotLit_q[i] == uca2eng));
      if (bcast_valid && slotValid[i] && (slotLit_q[i] == negBcast)) begin
        purgeConflict = 1'b1;
      end
    end
  end

  // Number of survivors, which is also where an accepted push lands
  always_comb begin
    keepCount = '0;
    for (int i = 0; i < DEPTH; i++) begin
      keepCount = keepCount + CNT_W'(keep[i]);
    end
  end

  // Look for the pushed literal or its complement among the survivors
  always_comb begin
    dupHit = 1'b0;
    negHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i] && (slotLit_q[i] == push_lit)) dupHit = 1'b1;
      if (keep[i] && (slotLit_q[i] == negPush))  negHit = 1'b1;
    end
  end

  assign pushReq       = push_valid && (push_lit != '0);
  assign bcSame        = bcast_valid && (push_lit == uca2eng);
  assign bcNeg         = bcast_valid && (push_lit == negBcast);
  assign pushConflict  = pushReq && !dupHit && !bcSame && (negHit || bcNeg);
  assign pushCandidate = pushReq && !dupHit && !bcSame && !negHit && !bcNeg;
  assign pushAccept    = pushCandidate && (keepCount < CNT_W'(DEPTH));
  assign pushOverflow  = pushCandidate && (keepCount >= CNT_W'(DEPTH));

  // Slide survivors down to their prefix-sum position and append the accepted push behind them
  always_comb begin : compactBlock
    logic [CNT_W-1:0] wrIdx;
    slotLit_d = '0;
    wrIdx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (keep[i]) begin
        slotLit_d[wrIdx[IDX_W-1:0]] = slotLit_q[i];
        wrIdx = wrIdx + CNT_W'(1);
      end
    end
    if (pushAccept) begin
      slotLit_d[keepCount[IDX_W-1:0]] = push_lit;
    end
  end

  assign count_d    = keepCount + CNT_W'(pushAccept);
  assign conflict_d = conflict_q | purgeConflict | pushConflict;
  assign overflow_d = overflow_q | pushOverflow;

  // Queue state and sticky flags; reset overrides everything else in its cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      slotLit_q  <= '0;
      count_q    <= '0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      slotLit_q  <= slotLit_d;
      count_q    <= count_d;
      conflict_q <= conflict_d;
      overflow_q <= overflow_d;
    end
  end

  assign eng2uca_empty = (count_q == '0);
  assign eng2uca_valid = !eng2uca_empty;
  assign eng2uca_full  = (count_q == CNT_W'(DEPTH));
  assign eng2uca_min   = eng2uca_empty ? LIT_W'(LIT_NONE) : slotLit_q[selIdx];
  assign conflict      = conflict_q;
  assign overflow      = overflow_q;
  assign count         = count_q;

endmodule

// File: tb/tb_eng_uc_queue.sv
// Directed bench for eng_uc_queue: stimulus queues hand-computed expectations,
// a negedge monitor pops them and compares against the presented outputs.
`timescale 1ns/1ps
module tb_eng_uc_queue;
  import uc_pkg::*;

  localparam int DEPTH = 8;
  localparam int LIT_W = LIT_W_DEF;

  logic clk = 1'b0;
  logic rst;
  logic push_valid;
  logic signed [LIT_W-1:0] push_lit;
  logic pop;
  logic bcast_valid;
  logic signed [LIT_W-1:0] uca2eng;
  logic input_mode;
  logic signed [LIT_W-1:0] eng2uca_min;
  logic eng2uca_valid;
  logic eng2uca_empty;
  logic eng2uca_full;
  logic conflict;
  logic overflow;
  logic [$clog2(DEPTH):0] count;

  typedef struct {
    string name;
    int    expMin;
    int    expCount;
    int    expConflict;
    int    expOverflow;
  } expect_t;

  expect_t sb[$];
  int checkCount = 0;
  int errorCount = 0;

  eng_uc_queue #(.DEPTH(DEPTH), .LIT_W(LIT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_lit      (push_lit),
    .pop           (pop),
    .bcast_valid   (bcast_valid),
    .uca2eng       (uca2eng),
    .input_mode    (input_mode),
    .eng2uca_min   (eng2uca_min),
    .eng2uca_valid (eng2uca_valid),
    .eng2uca_empty (eng2uca_empty),
    .eng2uca_full  (eng2uca_full),
    .conflict      (conflict),
    .overflow      (overflow),
    .count         (count)
  );

  always #5 clk = ~clk;

  task automatic compareField(input string name, input string field, input int act, input int exp);
    checkCount++;
    if (act != exp) begin
      errorCount++;
      $display("[TB] FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
    end
  endtask

  // Monitor: whenever an expectation is pending, compare it against the presented outputs
  always @(negedge clk) begin : monitor
    expect_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      compareField(e.name, "min",      int'($signed(eng2uca_min)), e.expMin);
      compareField(e.name, "count",    int'(count),                e.expCount);
      compareField(e.name, "valid",    int'(eng2uca_valid),        (e.expCount != 0) ? 1 : 0);
      compareField(e.name, "empty",    int'(eng2uca_empty),        (e.expCount == 0) ? 1 : 0);
      compareField(e.name, "full",     int'(eng2uca_full),         (e.expCount == DEPTH) ? 1 : 0);
      compareField(e.name, "conflict", int'(conflict),             e.expConflict);
      compareField(e.name, "overflow", int'(overflow),             e.expOverflow);
    end
  end

  // One clocked step: drive inputs after a posedge, let the next posedge capture them, then idle
  task automatic applyStimulus(input bit r, input bit pv, input int pl, input bit pp,
                               input bit bv, input int bl);
    @(posedge clk);
    #2;
    rst         = r;
    push_valid  = pv;
    push_lit    = pl[LIT_W-1:0];
    pop         = pp;
    bcast_valid = bv;
    uca2eng     = bl[LIT_W-1:0];
    @(posedge clk);
    #2;
    rst         = 1'b0;
    push_valid  = 1'b0;
    push_lit    = '0;
    pop         = 1'b0;
    bcast_valid = 1'b0;
    uca2eng     = '0;
  endtask

  task automatic checkOutput(input string name, input int expMin, input int expCount,
                             input int expConflict, input int expOverflow);
    expect_t e;
    e.name        = name;
    e.expMin      = expMin;
    e.expCount    = expCount;
    e.expConflict = expConflict;
    e.expOverflow = expOverflow;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic setMode(input bit m);
    @(posedge clk);
    #2;
    input_mode = m;
  endtask

  task automatic doPush(input int lit);
    applyStimulus(1'b0, 1'b1, lit, 1'b0, 1'b0, 0);
  endtask

  task automatic doPop();
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 0);
  endtask

  task automatic doBcast(input int lit);
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 1'b1, lit);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    push_valid  = 1'b0;
    push_lit    = '0;
    pop         = 1'b0;
    bcast_valid = 1'b0;
    uca2eng     = '0;
    input_mode  = 1'b0;

    doReset();
    checkOutput("reset", 0, 0, 0, 0);

    // FIFO ordering
    doPush(5);  checkOutput("fifoPush5", 5, 1, 0, 0);
    doPush(-3); checkOutput("fifoPushM3", 5, 2, 0, 0);
    doPush(7);  checkOutput("fifoPush7", 5, 3, 0, 0);
    doPop();    checkOutput("fifoPop1", -3, 2, 0, 0);
    doPop();    checkOutput("fifoPop2", 7, 1, 0, 0);
    doPop();    checkOutput("fifoPop3", 0, 0, 0, 0);
    doPop();    checkOutput("popEmpty", 0, 0, 0, 0);

    // Priority-queue ordering and complementary push
    setMode(1'b1);
    doPush(9);  checkOutput("pqPush9", 9, 1, 0, 0);
    doPush(-2); checkOutput("pqPushM2", -2, 2, 0, 0);
    doPush(4);  checkOutput("pqPush4", -2, 3, 0, 0);
    doPush(2);  checkOutput("pqConflict", -2, 3, 1, 0);
    doPop();    checkOutput("pqPop", 4, 2, 1, 0);
    setMode(1'b0);
    doReset();  checkOutput("resetAfterPq", 0, 0, 0, 0);

    // Full queue, overflow, push accepted alongside a pop
    for (int k = 1; k <= 8; k++) doPush(k);
    checkOutput("fill", 1, 8, 0, 0);
    doPush(9);  checkOutput("overflow", 1, 8, 0, 1);
    applyStimulus(1'b0, 1'b1, 10, 1'b1, 1'b0, 0);
    checkOutput("pushWithPop", 2, 8, 0, 1);
    for (int j = 1; j <= 7; j++) begin
      doPop();
      checkOutput("drain", (j < 7) ? (2 + j) : 10, 8 - j, 0, 1);
    end

    // Broadcast purge and conflict
    doReset();
    doPush(3);
    doPush(6);  checkOutput("bcFill", 3, 2, 0, 0);
    doBcast(6); checkOutput("bcPurge", 3, 1, 0, 0);
    doBcast(-3); checkOutput("bcConflict", 3, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 6, 1'b0, 1'b1, 6);
    checkOutput("bcPushDrop", 3, 1, 1, 0);

    // Pop and purge on the same slot, push against a complementary broadcast
    doReset();
    doPush(3);
    doPush(5);
    applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 3);
    checkOutput("popPurgeSame", 5, 1, 0, 0);
    applyStimulus(1'b0, 1'b1, -7, 1'b0, 1'b1, 7);
    checkOutput("pushBcNeg", 5, 1, 1, 0);

    // Duplicate and zero pushes
    doReset();
    doPush(4);
    doPush(4);
    doPush(0);
    checkOutput("dupZero", 4, 1, 0, 0);

    // Mode switch takes effect combinationally; reset beats a concurrent push
    doReset();
    doPush(8);
    doPush(1);
    doPush(5);  checkOutput("modeFifo", 8, 3, 0, 0);
    setMode(1'b1); checkOutput("modePqSameCycle", 1, 3, 0, 0);
    doPush(-1); checkOutput("pqNegStored", 1, 3, 1, 0);
    setMode(1'b0); checkOutput("modeBackFifo", 8, 3, 1, 0);
    applyStimulus(1'b1, 1'b1, 3, 1'b0, 1'b0, 0);
    checkOutput("resetWithPush", 0, 0, 0, 0);

    @(negedge clk);
    #1;
    compareField("scoreboard", "pending", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
